block_nest_checker: RTL and testbench

//  Streaming checker for begin/end nesting in an ASCII character stream, one char per accepted cycle.
//  It is the parametrised successor of the single-pair begin/end checker, used by the P1 text-processing datapath.

---
 rtl/p1_text_pkg.sv | 32 +++
 rtl/kw_matcher.sv | 70 +++++++
 rtl/block_nest_checker.sv | 83 ++++++++
 tb/tb_block_nest_checker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p1_text_pkg.sv
// Shared definitions for the P1 text-processing datapath: ASCII constants,
// keyword matcher state encoding and case folding.
package p1_text_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6E;
  localparam logic [7:0] CH_D     = 8'h64;
  localparam logic [7:0] CH_UC_A  = 8'h41;
  localparam logic [7:0] CH_UC_Z  = 8'h5A;

  typedef enum logic [3:0] {
    ST_SPACE,
    ST_SKIP,
    ST_B1,
    ST_B2,
    ST_B3,
    ST_B4,
    ST_BN,
    ST_E1,
    ST_E2,
    ST_ED
  } match_st_t;

  function automatic logic [7:0] tolower(input logic [7:0] c);
    return (c >= CH_UC_A && c <= CH_UC_Z) ? (c + 8'h20) : c;
  endfunction

endpackage

// File: rtl/kw_matcher.sv
// Word-level keyword recogniser: tracks "begin"/"end" per space-separated word
// and emits one-cycle token pulses on the accepted character that causes them.
module kw_matcher
  import p1_text_pkg::*;
#(
  parameter bit CASE_SENS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_ch,
  input  logic       i_valid,
  output logic       o_begin_set,
  output logic       o_end_set,
  output logic       o_commit,
  output logic       o_revoke
);

  match_st_t  r_state;
  match_st_t  w_state_nxt;
  logic [7:0] w_ch;
  logic       w_sp;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_SPACE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_ch        = CASE_SENS ? i_ch : tolower(i_ch);
    w_sp        = (i_ch == CH_SPACE);
    w_state_nxt = r_state;
    o_begin_set = 1'b0;
    o_end_set   = 1'b0;
    o_commit    = 1'b0;
    o_revoke    = 1'b0;
    if (i_valid) begin
      if (w_sp) w_state_nxt = ST_SPACE;
      else      w_state_nxt = ST_SKIP;
      case (r_state)
        ST_SPACE: begin
          if (w_ch == CH_B)      w_state_nxt = ST_B1;
          else if (w_ch == CH_E) w_state_nxt = ST_E1;
        end
        ST_B1: if (w_ch == CH_E) w_state_nxt = ST_B2;
        ST_B2: if (w_ch == CH_G) w_state_nxt = ST_B3;
        ST_B3: if (w_ch == CH_I) w_state_nxt = ST_B4;
        ST_B4: begin
          if (w_ch == CH_N) begin
            w_state_nxt = ST_BN;
            o_begin_set = 1'b1;
          end
        end
        ST_E1: if (w_ch == CH_N) w_state_nxt = ST_E2;
        ST_E2: begin
          if (w_ch == CH_D) begin
            w_state_nxt = ST_ED;
            o_end_set   = 1'b1;
          end
        end
        // A complete keyword is only final once the word ends on a space
        ST_BN, ST_ED: begin
          o_commit = w_sp;
          o_revoke = !w_sp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/block_nest_checker.sv
// Streaming begin/end nesting checker: committed depth, pending keyword,
// sticky underflow/overflow flags and a registered balanced indication.
module block_nest_checker
  import p1_text_pkg::*;
#(
  parameter int DEPTH_W   = 8,
  parameter int MAX_DEPTH = 255,
  parameter bit CASE_SENS = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               underflow,
  output logic               overflow
);

  logic                      w_begin_set, w_end_set, w_commit, w_revoke;
  logic        [DEPTH_W-1:0] r_depth, w_depth_nxt;
  logic signed [1:0]         r_pend, w_pend_nxt;
  logic                      r_uf, w_uf_nxt;
  logic                      r_of, w_of_nxt;
  logic                      r_result, w_result_nxt;
  logic signed [DEPTH_W:0]   w_pend_ext, w_eff;

  kw_matcher #(.CASE_SENS(CASE_SENS)) u_matcher (
    .clk        (clk),
    .reset      (reset),
    .i_ch       (in),
    .i_valid    (in_valid),
    .o_begin_set(w_begin_set),
    .o_end_set  (w_end_set),
    .o_commit   (w_commit),
    .o_revoke   (w_revoke)
  );

  always_comb begin
    w_depth_nxt = r_depth;
    w_pend_nxt  = r_pend;
    w_uf_nxt    = r_uf;
    w_of_nxt    = r_of;
    if (w_begin_set)            w_pend_nxt = 2'sd1;
    else if (w_end_set)         w_pend_nxt = -2'sd1;
    else if (w_commit || w_revoke) w_pend_nxt = 2'sd0;
    // Depth freezes once either sticky error has fired
    if (w_commit && !r_uf && !r_of) begin
      if (r_pend < 0) begin
        if (r_depth == '0) w_uf_nxt    = 1'b1;
        else               w_depth_nxt = r_depth - 1'b1;
      end else if (r_pend > 0) begin
        if (r_depth == MAX_DEPTH[DEPTH_W-1:0]) w_of_nxt    = 1'b1;
        else                                   w_depth_nxt = r_depth + 1'b1;
      end
    end
    w_pend_ext   = {{(DEPTH_W-1){w_pend_nxt[1]}}, w_pend_nxt};
    w_eff        = $signed({1'b0, w_depth_nxt}) + w_pend_ext;
    w_result_nxt = (w_eff == '0) && !w_uf_nxt && !w_of_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_depth  <= '0;
      r_pend   <= 2'sd0;
      r_uf     <= 1'b0;
      r_of     <= 1'b0;
      r_result <= 1'b1;
    end else begin
      r_depth  <= w_depth_nxt;
      r_pend   <= w_pend_nxt;
      r_uf     <= w_uf_nxt;
      r_of     <= w_of_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign result    = r_result;
  assign depth     = r_depth;
  assign underflow = r_uf;
  assign overflow  = r_of;

endmodule

// File: tb/tb_block_nest_checker.sv
// Bench for block_nest_checker: three configurations driven in parallel and
// compared against a whole-word reference model of the nesting rules.
module tb_block_nest_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_ch = 8'h20;
  logic       in_valid = 1'b0;

  logic       res_a, uf_a, of_a, res_b, uf_b, of_b, res_c, uf_c, of_c;
  logic [7:0] dep_a, dep_b, dep_c;
  logic [32:0] got_all;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  block_nest_checker #(.DEPTH_W(8), .MAX_DEPTH(255), .CASE_SENS(1'b0)) dut_a (
    .clk(clk), .reset(reset), .in(in_ch), .in_valid(in_valid),
    .result(res_a), .depth(dep_a), .underflow(uf_a), .overflow(of_a));
  block_nest_checker #(.DEPTH_W(8), .MAX_DEPTH(255), .CASE_SENS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .in(in_ch), .in_valid(in_valid),
    .result(res_b), .depth(dep_b), .underflow(uf_b), .overflow(of_b));
  block_nest_checker #(.DEPTH_W(8), .MAX_DEPTH(2), .CASE_SENS(1'b0)) dut_c (
    .clk(clk), .reset(reset), .in(in_ch), .in_valid(in_valid),
    .result(res_c), .depth(dep_c), .underflow(uf_c), .overflow(of_c));

  assign got_all = {res_a, dep_a, uf_a, of_a, res_b, dep_b, uf_b, of_b,
                    res_c, dep_c, uf_c, of_c};

  // Reference model: the current word is kept as text; a keyword is pending
  // while the word spells it exactly and is applied when a space ends it.
  int          m_depth [3];
  bit          m_uf    [3];
  bit          m_of    [3];
  logic [47:0] m_buf   [3];
  int          m_len   [3];
  int          m_cs    [3] = '{0, 1, 0};
  int          m_max   [3] = '{255, 255, 2};

  function automatic int pend_of(int k);
    if (m_len[k] == 5 && m_buf[k][39:0] == "begin") return 1;
    if (m_len[k] == 3 && m_buf[k][23:0] == "end")   return -1;
    return 0;
  endfunction

  function automatic logic [10:0] exp_one(int k);
    int  eff;
    logic r;
    eff = m_depth[k] + pend_of(k);
    r   = (eff == 0) && !m_uf[k] && !m_of[k];
    return {r, m_depth[k][7:0], m_uf[k], m_of[k]};
  endfunction

  function automatic logic [32:0] exp_all();
    return {exp_one(0), exp_one(1), exp_one(2)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_depth[k] = 0; m_uf[k] = 0; m_of[k] = 0; m_buf[k] = '0; m_len[k] = 0;
    end
  endtask

  task automatic model_char(input logic [7:0] ch);
    logic [7:0] c;
    int p;
    for (int k = 0; k < 3; k++) begin
      if (ch == 8'h20) begin
        p = pend_of(k);
        if (p != 0 && !m_uf[k] && !m_of[k]) begin
          if (p < 0 && m_depth[k] == 0)              m_uf[k] = 1;
          else if (p > 0 && m_depth[k] == m_max[k])  m_of[k] = 1;
          else                                       m_depth[k] += p;
        end
        m_buf[k] = '0;
        m_len[k] = 0;
      end else if (m_len[k] < 6) begin
        c = ch;
        if (m_cs[k] == 0 && c >= 8'h41 && c <= 8'h5A) c = c + 8'h20;
        m_buf[k] = {m_buf[k][39:0], c};
        m_len[k]++;
      end
    end
  endtask

  task automatic drive(input logic [7:0] ch, input logic v);
    in_ch = ch;
    in_valid = v;
    @(posedge clk);
    if (v) model_char(ch);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'($urandom);
    in_ch = 8'($urandom);
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (got_all !== {3{1'b1, 8'd0, 1'b0, 1'b0}}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", got_all, {3{1'b1, 8'd0, 1'b0, 1'b0}});
    end
  endtask

  task automatic test_basic();
    string s = "begin end ";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1'b1);
      checks++;
      if (got_all !== exp_all()) begin
        failures++;
        $display("FAIL basic char%0d got=%h exp=%h", i, got_all, exp_all());
      end
      if (i == 4) begin
        checks++;
        if (res_a !== 1'b0) begin
          failures++;
          $display("FAIL basic_result_after_n got=%b exp=0", res_a);
        end
      end
      if (i == 5) begin
        checks++;
        if (dep_a !== 8'd1) begin
          failures++;
          $display("FAIL basic_depth_after_space got=%0d exp=1", dep_a);
        end
      end
    end
    checks++;
    if ({res_a, dep_a, uf_a, of_a} !== {1'b1, 8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_final got=%b/%0d/%b/%b exp=1/0/0/0", res_a, dep_a, uf_a, of_a);
    end
  endtask

  task automatic test_case_fold();
    string s = "BeGiN  eNd ";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1'b1);
      checks++;
      if (got_all !== exp_all()) begin
        failures++;
        $display("FAIL case char%0d got=%h exp=%h", i, got_all, exp_all());
      end
      checks++;
      if (res_b !== 1'b1 || dep_b !== 8'd0) begin
        failures++;
        $display("FAIL case_sens_idle char%0d got=%b/%0d exp=1/0", i, res_b, dep_b);
      end
    end
    checks++;
    if (res_a !== 1'b1) begin
      failures++;
      $display("FAIL case_fold_final got=%b exp=1", res_a);
    end
  endtask

  task automatic test_underflow();
    string s = "beginx end begin end ";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1'b1);
      checks++;
      if (got_all !== exp_all()) begin
        failures++;
        $display("FAIL underflow char%0d got=%h exp=%h", i, got_all, exp_all());
      end
    end
    checks++;
    if (uf_a !== 1'b1 || res_a !== 1'b0 || dep_a !== 8'd0) begin
      failures++;
      $display("FAIL underflow_sticky got=%b/%b/%0d exp=1/0/0", uf_a, res_a, dep_a);
    end
  endtask

  task automatic test_overflow();
    string s = "begin begin begin ";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1'b1);
      checks++;
      if (got_all !== exp_all()) begin
        failures++;
        $display("FAIL overflow char%0d got=%h exp=%h", i, got_all, exp_all());
      end
    end
    checks++;
    if (dep_c !== 8'd2 || of_c !== 1'b1 || res_c !== 1'b0) begin
      failures++;
      $display("FAIL overflow_limit got=%0d/%b/%b exp=2/1/0", dep_c, of_c, res_c);
    end
  endtask

  task automatic test_no_trailing();
    string s = "begin";
    do_reset();
    for (int i = 0; i < s.len(); i++) drive(s[i], 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(8'($urandom_range(32, 126)), 1'b0);
      checks++;
      if (res_a !== 1'b0 || dep_a !== 8'd0 || got_all !== exp_all()) begin
        failures++;
        $display("FAIL pending_hold idle%0d got=%b/%0d all=%h exp=0/0 all=%h",
                 i, res_a, dep_a, got_all, exp_all());
      end
    end
  endtask

  task automatic test_reset_midword();
    string s1 = "begin be";
    string s2 = "end end ";
    do_reset();
    for (int i = 0; i < s1.len(); i++) drive(s1[i], 1'b1);
    do_reset();
    for (int i = 0; i < s2.len(); i++) begin
      drive(s2[i], 1'b1);
      checks++;
      if (got_all !== exp_all()) begin
        failures++;
        $display("FAIL reset_mid char%0d got=%h exp=%h", i, got_all, exp_all());
      end
    end
    checks++;
    if (uf_a !== 1'b1 || dep_a !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_underflow got=%b/%0d exp=1/0", uf_a, dep_a);
    end
  endtask

  task automatic test_random();
    logic [7:0] tbl [16] = '{8'h62, 8'h42, 8'h65, 8'h45, 8'h67, 8'h47, 8'h69, 8'h49,
                             8'h6E, 8'h4E, 8'h64, 8'h44, 8'h78, 8'h20, 8'h20, 8'h20};
    string kw [4] = '{"begin ", "end ", "Begin ", "eNd "};
    string w;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 9) == 0) begin
        w = kw[$urandom_range(0, 3)];
        for (int i = 0; i < w.len(); i++) begin
          drive(w[i], 1'b1);
          checks++;
          if (got_all !== exp_all()) begin
            failures++;
            $display("FAIL random_kw n%0d got=%h exp=%h", n, got_all, exp_all());
          end
        end
      end else begin
        drive(tbl[$urandom_range(0, 15)], ($urandom_range(0, 3) != 0));
      end
      checks++;
      if (got_all !== exp_all()) begin
        failures++;
        $display("FAIL random n%0d got=%h exp=%h", n, got_all, exp_all());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_case_fold();
    test_underflow();
    test_overflow();
    test_no_trailing();
    test_reset_midword();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
